// File: rtl/bsg_clk_gen_tag_sequencer.sv
// Expands one clock-generator configuration into a fixed script of bsg_tag packets
// and shifts them out LSB first on a single serial line.
//
// state | meaning
// idle  | waiting for a configuration, cfg_ready_o high
// load  | building the next packet into the shift register, line held low
// shift | one packet bit per cycle
// gap   | gap_cycles_p idle zero bits after a packet
// done  | one-cycle done_o pulse before returning to idle
module bsg_clk_gen_tag_sequencer #(
   parameter int tag_els_p      = 16,
   parameter int tag_lg_width_p = 4,
   parameter int node_base_p    = 0,
   parameter int osc_width_p    = 10,
   parameter int ds_width_p     = 8,
   parameter int gap_cycles_p   = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   cfg_v_i,
   output logic                   cfg_ready_o,
   input  logic                   cfg_init_i,
   input  logic [osc_width_p-1:0] cfg_osc_i,
   input  logic [ds_width_p-1:0]  cfg_ds_i,
   input  logic [1:0]             cfg_sel_i,
   output logic                   tag_data_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int id_w          = $clog2(tag_els_p);
   localparam int max_payload_lp = (1 << tag_lg_width_p) - 1;
   localparam int hdr_bits_lp   = 2 + id_w + tag_lg_width_p;
   localparam int pkt_w_lp      = hdr_bits_lp + max_payload_lp;
   localparam int cnt_w_lp      = $clog2(pkt_w_lp + 1);
   localparam int gap_w_lp      = (gap_cycles_p > 1) ? $clog2(gap_cycles_p) : 1;

   localparam logic [id_w-1:0] base_lp     = id_w'(node_base_p);
   localparam logic [3:0]      first_data_lp = 4'd6;
   localparam logic [3:0]      last_pkt_lp   = 4'd12;

   typedef enum logic [2:0] {
      e_idle  = 3'd0,
      e_load  = 3'd1,
      e_shift = 3'd2,
      e_gap   = 3'd3,
      e_done  = 3'd4
   } state_e;

   state_e                  state_r;
   logic                    init_r;
   logic [osc_width_p-1:0]  osc_r;
   logic [ds_width_p-1:0]   ds_r;
   logic [1:0]              sel_r;
   logic [3:0]              pkt_idx_r;
   logic [pkt_w_lp-1:0]     sr_r;
   logic [cnt_w_lp-1:0]     bits_left_r;
   logic [gap_w_lp-1:0]     gap_left_r;

   logic [id_w-1:0]           pkt_off;
   logic                      pkt_dnr;
   logic [tag_lg_width_p-1:0] pkt_len;
   logic [max_payload_lp-1:0] pkt_payload;
   logic [pkt_w_lp-1:0]       pkt_vec;
   logic [cnt_w_lp-1:0]       pkt_bits;

   // Script: indices 0..5 are the optional client reset packets, 6..12 the data packets.
   always_comb begin
      pkt_off     = '0;
      pkt_dnr     = 1'b1;
      pkt_len     = tag_lg_width_p'(1);
      pkt_payload = '0;
      if (pkt_idx_r < first_data_lp) begin
         pkt_off     = id_w'(pkt_idx_r);
         pkt_dnr     = 1'b0;
         pkt_payload = max_payload_lp'(1);
      end else begin
         case (pkt_idx_r)
            4'd6: begin
               pkt_off     = id_w'(0);
               pkt_payload = max_payload_lp'(1);
            end
            4'd7: begin
               pkt_off     = id_w'(1);
               pkt_len     = tag_lg_width_p'(osc_width_p);
               pkt_payload = max_payload_lp'(osc_r);
            end
            4'd8: begin
               pkt_off     = id_w'(2);
               pkt_payload = max_payload_lp'(1);
            end
            4'd9: pkt_off = id_w'(2);
            4'd10: pkt_off = id_w'(0);
            4'd11: begin
               pkt_off     = id_w'(3);
               pkt_len     = tag_lg_width_p'(ds_width_p + 1);
               pkt_payload = max_payload_lp'({ds_r, 1'b0});
            end
            default: begin
               pkt_off     = id_w'(4);
               pkt_len     = tag_lg_width_p'(2);
               pkt_payload = max_payload_lp'(sel_r);
            end
         endcase
      end
      pkt_vec  = {pkt_payload, pkt_len, pkt_dnr, base_lp + pkt_off, 1'b1};
      pkt_bits = cnt_w_lp'(hdr_bits_lp) + cnt_w_lp'(pkt_len);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= e_idle;
         init_r      <= 1'b0;
         osc_r       <= '0;
         ds_r        <= '0;
         sel_r       <= '0;
         pkt_idx_r   <= '0;
         sr_r        <= '0;
         bits_left_r <= '0;
         gap_left_r  <= '0;
         tag_data_o  <= 1'b0;
         cfg_ready_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_r)
            e_idle: begin
               cfg_ready_o <= 1'b1;
               busy_o      <= 1'b0;
               tag_data_o  <= 1'b0;
               if (cfg_v_i && cfg_ready_o) begin
                  init_r      <= cfg_init_i;
                  osc_r       <= cfg_osc_i;
                  ds_r        <= cfg_ds_i;
                  sel_r       <= cfg_sel_i;
                  pkt_idx_r   <= cfg_init_i ? 4'd0 : first_data_lp;
                  cfg_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  state_r     <= e_load;
               end
            end
            e_load: begin
               tag_data_o  <= pkt_vec[0];
               sr_r        <= pkt_vec >> 1;
               bits_left_r <= pkt_bits - cnt_w_lp'(1);
               state_r     <= e_shift;
            end
            e_shift: begin
               if (bits_left_r == '0) begin
                  tag_data_o <= 1'b0;
                  gap_left_r <= gap_w_lp'(gap_cycles_p - 1);
                  state_r    <= e_gap;
               end else begin
                  tag_data_o  <= sr_r[0];
                  sr_r        <= sr_r >> 1;
                  bits_left_r <= bits_left_r - cnt_w_lp'(1);
               end
            end
            e_gap: begin
               if (gap_left_r == '0) begin
                  if (pkt_idx_r == last_pkt_lp) begin
                     done_o  <= 1'b1;
                     state_r <= e_done;
                  end else begin
                     pkt_idx_r <= pkt_idx_r + 4'd1;
                     state_r   <= e_load;
                  end
               end else begin
                  gap_left_r <= gap_left_r - gap_w_lp'(1);
               end
            end
            e_done: begin
               busy_o      <= 1'b0;
               cfg_ready_o <= 1'b1;
               state_r     <= e_idle;
            end
            default: state_r <= e_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_clk_gen_tag_sequencer.sv
// Randomized bench for the tag sequencer: expected serial streams come from a
// packet-list model of the script, compared bit by bit on the falling edge.
module tb_bsg_clk_gen_tag_sequencer;

   localparam int ID_W  = 4;
   localparam int LG_W  = 4;
   localparam int OSC_W = 10;
   localparam int DS_W  = 8;
   localparam int GAP   = 4;

   logic             clk_i = 1'b0;
   logic             reset_n_i = 1'b0;
   logic             cfg_v_i = 1'b0;
   logic             cfg_ready_o;
   logic             cfg_init_i = 1'b0;
   logic [OSC_W-1:0] cfg_osc_i = '0;
   logic [DS_W-1:0]  cfg_ds_i = '0;
   logic [1:0]       cfg_sel_i = '0;
   logic             tag_data_o;
   logic             busy_o;
   logic             done_o;

   int n_checks = 0;
   int n_pass   = 0;
   bit exp_q[$];
   logic [15:0] last16;

   bsg_clk_gen_tag_sequencer dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .cfg_v_i     (cfg_v_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_init_i  (cfg_init_i),
      .cfg_osc_i   (cfg_osc_i),
      .cfg_ds_i    (cfg_ds_i),
      .cfg_sel_i   (cfg_sel_i),
      .tag_data_o  (tag_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // One packet as seen on the line: a load cycle (0), the packet bits, then the gap.
   task automatic push_pkt(input int id, input int dnr, input int len, input int payload);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      for (int i = 0; i < ID_W; i++) exp_q.push_back(bit'((id >> i) & 1));
      exp_q.push_back(bit'(dnr));
      for (int i = 0; i < LG_W; i++) exp_q.push_back(bit'((len >> i) & 1));
      for (int i = 0; i < len; i++) exp_q.push_back(bit'((payload >> i) & 1));
      for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
   endtask

   task automatic build_exp(input bit init, input int osc, input int ds, input int sel);
      exp_q.delete();
      if (init) for (int c = 0; c < 6; c++) push_pkt(c, 0, 1, 1);
      push_pkt(0, 1, 1, 1);
      push_pkt(1, 1, OSC_W, osc);
      push_pkt(2, 1, 1, 1);
      push_pkt(2, 1, 1, 0);
      push_pkt(0, 1, 1, 0);
      push_pkt(3, 1, DS_W + 1, ds * 2);
      push_pkt(4, 1, 2, sel);
   endtask

   // mode 0: plain run; 1: hold cfg_v_i with changing data while busy; 2: reset at abort_at
   task automatic run_cfg(input bit init, input logic [OSC_W-1:0] osc, input logic [DS_W-1:0] ds,
                          input logic [1:0] sel, input int mode, input int abort_at);
      int waited;
      waited = 0;
      last16 = '0;
      build_exp(init, int'(osc), int'(ds), int'(sel));
      while (!cfg_ready_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      chk("ready_wait", cfg_ready_o, 1);
      cfg_v_i    = 1'b1;
      cfg_init_i = init;
      cfg_osc_i  = osc;
      cfg_ds_i   = ds;
      cfg_sel_i  = sel;
      @(negedge clk_i);
      chk("accept_busy", busy_o, 1);
      chk("accept_ready", cfg_ready_o, 0);
      if (mode != 1) cfg_v_i = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) @(negedge clk_i);
         chk("tag_bit", tag_data_o, exp_q[i]);
         chk("done_early", done_o, 0);
         last16 = {last16[14:0], tag_data_o};
         if (mode == 1) begin
            chk("ready_busy", cfg_ready_o, 0);
            cfg_init_i = 1'($urandom);
            cfg_osc_i  = OSC_W'($urandom);
            cfg_ds_i   = DS_W'($urandom);
            cfg_sel_i  = 2'($urandom);
         end
         if (mode == 2 && i == abort_at) begin
            reset_n_i = 1'b0;
            #1;
            chk("abort_tag", tag_data_o, 0);
            chk("abort_busy", busy_o, 0);
            chk("abort_ready", cfg_ready_o, 0);
            chk("abort_done", done_o, 0);
            return;
         end
      end
      @(negedge clk_i);
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 1);
      chk("done_tag", tag_data_o, 0);
      cfg_v_i = 1'b0;
      @(negedge clk_i);
      chk("post_done", done_o, 0);
      chk("post_ready", cfg_ready_o, 1);
      chk("post_busy", busy_o, 0);
      if (mode == 1) begin
         @(negedge clk_i);
         chk("no_late_accept", busy_o, 0);
      end
   endtask

   initial begin
      int abort_i;
      logic [OSC_W-1:0] osc_a;
      logic [15:0] sel_pkt_exp;

      @(negedge clk_i);
      chk("rst_tag", tag_data_o, 0);
      chk("rst_ready", cfg_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      reset_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("idle_ready", cfg_ready_o, 1);
         chk("idle_tag", tag_data_o, 0);
         chk("idle_busy", busy_o, 0);
      end

      run_cfg(1'b0, 10'h155, 8'h5A, 2'b11, 0, 0);
      sel_pkt_exp = 16'b1001_0101_0011_0000;
      chk("sel_pkt_bits", last16, sel_pkt_exp);

      run_cfg(1'b1, 10'h2A5, 8'h03, 2'b01, 0, 0);

      run_cfg(1'b0, 10'h0F0, 8'hC3, 2'b10, 1, 0);
      run_cfg(1'b1, 10'h001, 8'hFF, 2'b00, 0, 0);

      for (int r = 0; r < 4; r++)
         run_cfg(1'($urandom), OSC_W'($urandom), DS_W'($urandom), 2'($urandom), 0, 0);

      // Abort on a 1 inside the osc payload: 6 init packets plus async_reset precede it.
      osc_a = OSC_W'($urandom) | 10'h200;
      build_exp(1'b1, int'(osc_a), 7, 2);
      abort_i = 7 * 16 + 11;
      while (abort_i < exp_q.size() && exp_q[abort_i] == 1'b0) abort_i++;
      run_cfg(1'b1, osc_a, 8'h07, 2'b10, 2, abort_i);
      repeat (2) begin
         @(negedge clk_i);
         chk("hold_rst_tag", tag_data_o, 0);
         chk("hold_rst_ready", cfg_ready_o, 0);
      end
      reset_n_i = 1'b1;
      @(negedge clk_i);
      chk("rerst_ready", cfg_ready_o, 1);
      chk("rerst_busy", busy_o, 0);
      run_cfg(1'b1, 10'h3C7, 8'h81, 2'b01, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
